// File: rtl/encrypter_host.sv
// encrypter_host: bus-initiator front end that runs one encryption per
// accepted operand pair over the byte-wide encrypter register port.
module encrypter_host #(
    parameter int unsigned SET_HOLD   = 2,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_data,
    input  logic [0:63] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_data,
    output logic [0:63] out_key,
    output logic        out_timeout,
    output logic [0:7]  byte_write,
    output logic [5:0]  addr,
    output logic        we,
    output logic        re,
    input  logic [0:7]  byte_read
);

    localparam int unsigned CNT_MAX = (SET_HOLD > 16) ? SET_HOLD : 16;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned POLL_W  = $clog2(POLL_LIMIT + 1);
    localparam logic [0:7]  SET_CMD = 8'b1000_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WRITE,
        S_SET,
        S_HOLD,
        S_CLEAR,
        S_GAP,
        S_POLL_RD,
        S_POLL_CHK,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [0:127]        opnd_q, opnd_d;
    logic [0:127]        res_q, res_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic [5:0]          addr_q, addr_d;
    logic [0:7]          wbyte_q, wbyte_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_timeout_q, out_timeout_d;
    logic [3:0]          idx_nxt;
    logic [POLL_W-1:0]   poll_inc;

    // Operand byte n goes to data-in (1..8) for n<8, key-in (17..24) otherwise.
    function automatic logic [5:0] wr_addr(input logic [3:0] idx);
        return idx[3] ? (6'd9 + 6'(idx)) : (6'd1 + 6'(idx));
    endfunction

    // State, counters, operand/result storage and registered bus/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            poll_q        <= '0;
            opnd_q        <= '0;
            res_q         <= '0;
            we_q          <= 1'b0;
            re_q          <= 1'b0;
            addr_q        <= '0;
            wbyte_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            poll_q        <= poll_d;
            opnd_q        <= opnd_d;
            res_q         <= res_d;
            we_q          <= we_d;
            re_q          <= re_d;
            addr_q        <= addr_d;
            wbyte_q       <= wbyte_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_timeout_q <= out_timeout_d;
        end
    end

    // Next state plus the bus values for the cycle being entered, so outputs come straight from flops.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        poll_d        = poll_q;
        opnd_d        = opnd_q;
        res_d         = res_q;
        we_d          = 1'b0;
        re_d          = 1'b0;
        addr_d        = '0;
        wbyte_d       = '0;
        out_valid_d   = out_valid_q;
        out_timeout_d = out_timeout_q;
        idx_nxt       = cnt_q[3:0] + 4'd1;
        poll_inc      = (poll_q == POLL_W'(POLL_LIMIT)) ? poll_q : (poll_q + POLL_W'(1));

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opnd_d  = {in_data, in_key};
                    res_d   = '0;
                    poll_d  = '0;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    addr_d  = 6'd1;
                    wbyte_d = in_data[0:7];
                end
            end
            S_WRITE: begin
                we_d = 1'b1;
                if (cnt_q[3:0] == 4'd15) begin
                    state_d = S_SET;
                    wbyte_d = SET_CMD;
                end else begin
                    cnt_d   = CNT_W'(idx_nxt);
                    addr_d  = wr_addr(idx_nxt);
                    wbyte_d = opnd_q[{idx_nxt, 3'b000} +: 8];
                end
            end
            S_SET: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(SET_HOLD - 1)) begin
                    state_d = S_CLEAR;
                    we_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEAR: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_POLL_RD;
                    re_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_POLL_RD: begin
                state_d = S_POLL_CHK;
            end
            S_POLL_CHK: begin
                if (byte_read[4]) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    re_d    = 1'b1;
                    addr_d  = 6'd9;
                end else begin
                    poll_d = poll_inc;
                    if (poll_inc == POLL_W'(POLL_LIMIT)) begin
                        state_d       = S_DONE;
                        out_valid_d   = 1'b1;
                        out_timeout_d = 1'b1;
                        res_d         = '0;
                    end else begin
                        state_d = S_POLL_RD;
                        re_d    = 1'b1;
                    end
                end
            end
            S_READ: begin
                // byte_read lags re by one cycle, so this cycle returns the previous address.
                if (cnt_q[3:0] != 4'd0) begin
                    res_d[{cnt_q[3:0] - 4'd1, 3'b000} +: 8] = byte_read;
                end
                if (cnt_q[3:0] == 4'd15) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d  = CNT_W'(idx_nxt);
                    re_d   = 1'b1;
                    addr_d = 6'd9 + 6'(idx_nxt);
                end
            end
            S_DRAIN: begin
                res_d[120 +: 8] = byte_read;
                state_d         = S_DONE;
                out_valid_d     = 1'b1;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b0;
                    out_timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_timeout = out_timeout_q;
    assign out_data    = res_q[0:63];
    assign out_key     = res_q[64:127];
    assign byte_write  = wbyte_q;
    assign addr        = addr_q;
    assign we          = we_q;
    assign re          = re_q;

endmodule

// File: tb/tb_encrypter_host.sv
// Directed bench for encrypter_host with a behavioural register-interface responder.
module tb_encrypter_host;

    localparam int SET_HOLD   = 2;
    localparam int POLL_LIMIT = 4;
    localparam int EXP_POLLS  = 3;
    localparam int LAT_OK     = 16 + 1 + SET_HOLD + 1 + 2 + 2 * EXP_POLLS + 17;
    localparam int LAT_TO     = 16 + 1 + SET_HOLD + 1 + 2 + 2 * POLL_LIMIT;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_data;
    logic [0:63] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_data;
    logic [0:63] out_key;
    logic        out_timeout;
    logic [0:7]  byte_write;
    logic [5:0]  addr;
    logic        we;
    logic        re;
    logic [0:7]  byte_read = 8'h00;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    encrypter_host #(
        .SET_HOLD  (SET_HOLD),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_key    (out_key),
        .out_timeout(out_timeout),
        .byte_write (byte_write),
        .addr       (addr),
        .we         (we),
        .re         (re),
        .byte_read  (byte_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: ciphertext = data ^ key, round key = ~key, status a few cycles after clear.
    logic [0:7] regs [0:24] = '{default: 8'h00};
    bit armed        = 1'b0;
    bit never_set    = 1'b0;
    int countdown    = 0;
    int status_delay = 5;

    always @(posedge clk) begin
        if (re && addr <= 6'd24) byte_read <= regs[addr];
        if (we) begin
            if (addr == 6'd0) begin
                if (byte_write[0]) armed <= 1'b1;
                else begin
                    regs[0] <= 8'h00;
                    if (armed && !never_set) countdown <= status_delay;
                    armed <= 1'b0;
                end
            end else if (addr <= 6'd24) begin
                regs[addr] <= byte_write;
            end
        end
        if (countdown > 0) begin
            countdown <= countdown - 1;
            if (countdown == 1) begin
                regs[0][4] <= 1'b1;
                for (int k = 0; k < 8; k++) begin
                    regs[9 + k]  <= regs[1 + k] ^ regs[17 + k];
                    regs[17 + k] <= ~regs[17 + k];
                end
            end
        end
    end

    // Bus trace and bus-rule monitor.
    logic [5:0] wr_a [$];
    logic [0:7] wr_b [$];
    logic [5:0] rd_a [$];
    int polls    = 0;
    int bus_viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (we && re) bus_viol <= bus_viol + 1;
            else if (!we && byte_write != 8'h00) bus_viol <= bus_viol + 1;
            else if (!we && !re && addr != 6'd0) bus_viol <= bus_viol + 1;
            if (we) begin
                wr_a.push_back(addr);
                wr_b.push_back(byte_write);
            end
            if (re && addr == 6'd0) polls <= polls + 1;
            if (re && addr != 6'd0) rd_a.push_back(addr);
        end
    end

    function automatic logic [0:63] exp_ct(input logic [0:63] d, input logic [0:63] k);
        return d ^ k;
    endfunction

    function automatic logic [0:63] exp_rk(input logic [0:63] k);
        return ~k;
    endfunction

    // Called at a negedge with in_valid already high; returns the accept edge index.
    task automatic wait_accept(output int acc, output bit ok);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic wait_out(output int t, output bit ok);
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
        t  = cyc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_key = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_timeout} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_handshake: got rdy/vld/to=%b want 100", {in_ready, out_valid, out_timeout});
        end
        vectors++;
        if ({out_data, out_key} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h %h want zero", out_data, out_key);
        end
        vectors++;
        if ({we, re, addr, byte_write} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got we=%b re=%b addr=%0d byte=%h want all zero", we, re, addr, byte_write);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [7:0] exp_b [18] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                                   8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78,
                                   8'h80, 8'h00};
        logic [5:0] exp_a;
        int mw = wr_a.size();
        int mr = rd_a.size();
        int p0 = polls;
        int acc, t;
        bit ok;
        in_data = 64'h0123456789ABCDEF; in_key = 64'h0F1E2D3C4B5A6978; in_valid = 1'b1;
        wait_accept(acc, ok);
        in_valid = 1'b0;
        wait_out(t, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_out_valid: got 0 want 1 within bound");
        end
        vectors++;
        if (t - acc != LAT_OK) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want %0d", t - acc, LAT_OK);
        end
        vectors++;
        if (polls - p0 != EXP_POLLS) begin
            miscompares++;
            $display("FAIL basic_polls: got %0d want %0d", polls - p0, EXP_POLLS);
        end
        vectors++;
        if (out_data !== 64'h0E3D685BC2F1A497) begin
            miscompares++;
            $display("FAIL basic_out_data: got %h want 0e3d685bc2f1a497", out_data);
        end
        vectors++;
        if ({out_key, out_timeout} !== {64'hF0E1D2C3B4A59687, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_out_key: got %h to=%b want f0e1d2c3b4a59687 to=0", out_key, out_timeout);
        end
        vectors++;
        if (wr_a.size() - mw != 18 || rd_a.size() - mr != 16) begin
            miscompares++;
            $display("FAIL basic_trace_len: got wr=%0d rd=%0d want 18 16", wr_a.size() - mw, rd_a.size() - mr);
        end else begin
            for (int i = 0; i < 18; i++) begin
                exp_a = (i < 8) ? 6'(i + 1) : (i < 16) ? 6'(i + 9) : 6'd0;
                vectors++;
                if (wr_a[mw + i] !== exp_a || wr_b[mw + i] !== exp_b[i]) begin
                    miscompares++;
                    $display("FAIL basic_write_%0d: got addr %0d byte %h want addr %0d byte %h",
                             i, wr_a[mw + i], wr_b[mw + i], exp_a, exp_b[i]);
                end
            end
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (rd_a[mr + i] !== 6'(9 + i)) begin
                    miscompares++;
                    $display("FAIL basic_read_%0d: got addr %0d want %0d", i, rd_a[mr + i], 9 + i);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [0:63] d1 = 64'h1122334455667788, k1 = 64'h8877665544332211;
        logic [0:63] d2 = 64'hA5A55A5AC3C33C3C, k2 = 64'h0011223344556677;
        logic [0:63] od, ok_key;
        int acc, t;
        bit ok;
        in_data = d1; in_key = k1; in_valid = 1'b1; out_ready = 1'b0;
        wait_accept(acc, ok);
        in_valid = 1'b0;
        wait_out(t, ok);
        od = out_data; ok_key = out_key;
        vectors++;
        if (od !== exp_ct(d1, k1) || ok_key !== exp_rk(k1)) begin
            miscompares++;
            $display("FAIL bp_result: got %h %h want %h %h", od, ok_key, exp_ct(d1, k1), exp_rk(k1));
        end
        in_data = d2; in_key = k2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, in_ready, out_data, out_key} !== {1'b1, 1'b0, od, ok_key}) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b data=%h want vld=1 rdy=0 data=%h",
                         i, out_valid, in_ready, out_data, od);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: got vld/rdy=%b want 01", {out_valid, in_ready});
        end
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
        vectors++;
        if ({in_ready, we, addr, byte_write} !== {1'b0, 1'b1, 6'd1, 8'hA5}) begin
            miscompares++;
            $display("FAIL bp_next_accept: got rdy=%b we=%b addr=%0d byte=%h want 0 1 1 a5",
                     in_ready, we, addr, byte_write);
        end
        wait_out(t, ok);
        vectors++;
        if (t - acc != LAT_OK || out_data !== exp_ct(d2, k2) || out_key !== exp_rk(k2)) begin
            miscompares++;
            $display("FAIL bp_second: got lat=%0d %h %h want lat=%0d %h %h",
                     t - acc, out_data, out_key, LAT_OK, exp_ct(d2, k2), exp_rk(k2));
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        logic [0:63] d = 64'hDEADBEEF01020304, k = 64'h55AA55AA12345678;
        int p0 = polls;
        int acc, t;
        bit ok;
        never_set = 1'b1;
        in_data = d; in_key = k; in_valid = 1'b1;
        wait_accept(acc, ok);
        in_valid = 1'b0;
        wait_out(t, ok);
        vectors++;
        if (t - acc != LAT_TO || polls - p0 != POLL_LIMIT) begin
            miscompares++;
            $display("FAIL to_timing: got lat=%0d polls=%0d want lat=%0d polls=%0d",
                     t - acc, polls - p0, LAT_TO, POLL_LIMIT);
        end
        vectors++;
        if ({out_valid, out_timeout, out_data, out_key} !== {2'b11, 128'h0}) begin
            miscompares++;
            $display("FAIL to_result: got vld=%b to=%b %h %h want 1 1 zero",
                     out_valid, out_timeout, out_data, out_key);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, out_timeout, in_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL to_clear: got vld/to/rdy=%b want 001", {out_valid, out_timeout, in_ready});
        end
        never_set = 1'b0;
        d = 64'h0F0F0F0FF0F0F0F0; k = 64'h123456789ABCDEF0;
        in_data = d; in_key = k; in_valid = 1'b1;
        wait_accept(acc, ok);
        in_valid = 1'b0;
        wait_out(t, ok);
        vectors++;
        if (out_timeout !== 1'b0 || out_data !== exp_ct(d, k) || out_key !== exp_rk(k)) begin
            miscompares++;
            $display("FAIL to_recover: got to=%b %h %h want 0 %h %h",
                     out_timeout, out_data, out_key, exp_ct(d, k), exp_rk(k));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write;
        logic [0:63] d = 64'hCAFEF00D8BADF00D, k = 64'h1357924680ACEBDF;
        int acc, t;
        bit ok;
        in_data = 64'hFFFF0000FFFF0000; in_key = 64'h0000FFFF0000FFFF; in_valid = 1'b1;
        wait_accept(acc, ok);
        repeat (6) @(negedge clk);
        vectors++;
        if ({we, addr} !== {1'b1, 6'd7}) begin
            miscompares++;
            $display("FAIL rst_pre: got we=%b addr=%0d want 1 7", we, addr);
        end
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if ({we, re, addr, byte_write} !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_async_bus: got we=%b re=%b addr=%0d byte=%h want zero", we, re, addr, byte_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_release: got rdy/vld=%b want 10", {in_ready, out_valid});
        end
        in_data = d; in_key = k; in_valid = 1'b1;
        wait_accept(acc, ok);
        in_valid = 1'b0;
        wait_out(t, ok);
        vectors++;
        if (t - acc != LAT_OK || out_data !== exp_ct(d, k) || out_key !== exp_rk(k)) begin
            miscompares++;
            $display("FAIL rst_after: got lat=%0d %h %h want lat=%0d %h %h",
                     t - acc, out_data, out_key, LAT_OK, exp_ct(d, k), exp_rk(k));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [0:63] d1 = 64'h0102030405060708, k1 = 64'hF1E2D3C4B5A69788;
        logic [0:63] d2 = 64'h7766554433221100, k2 = 64'h00FF00FF00FF00FF;
        int acc, t;
        bit ok;
        in_data = d1; in_key = k1; in_valid = 1'b1;
        wait_accept(acc, ok);
        in_data = d2; in_key = k2;
        wait_out(t, ok);
        vectors++;
        if (out_data !== exp_ct(d1, k1) || out_key !== exp_rk(k1)) begin
            miscompares++;
            $display("FAIL b2b_first: got %h %h want %h %h", out_data, out_key, exp_ct(d1, k1), exp_rk(k1));
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_gap: got vld/rdy=%b want 01", {out_valid, in_ready});
        end
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
        vectors++;
        if ({in_ready, we, addr} !== {1'b0, 1'b1, 6'd1}) begin
            miscompares++;
            $display("FAIL b2b_accept: got rdy=%b we=%b addr=%0d want 0 1 1", in_ready, we, addr);
        end
        wait_out(t, ok);
        vectors++;
        if (t - acc != LAT_OK || out_data !== exp_ct(d2, k2) || out_key !== exp_rk(k2)) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d %h %h want lat=%0d %h %h",
                     t - acc, out_data, out_key, LAT_OK, exp_ct(d2, k2), exp_rk(k2));
        end
        @(negedge clk);
    endtask

    task automatic test_busy_input;
        logic [0:63] d = 64'h89ABCDEF01234567, k = 64'h2468ACE013579BDF;
        int acc, t;
        int n = 0;
        bit ok;
        in_data = d; in_key = k; in_valid = 1'b1;
        wait_accept(acc, ok);
        in_valid = 1'b0;
        while (!(re && addr == 6'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!(re && addr == 6'd0)) begin
            miscompares++;
            $display("FAIL busy_reach_poll: got no poll read, want poll within bound");
        end
        in_data = ~d; in_key = ~k; in_valid = 1'b1;
        wait_out(t, ok);
        in_valid = 1'b0;
        vectors++;
        if (out_data !== exp_ct(d, k) || out_key !== exp_rk(k)) begin
            miscompares++;
            $display("FAIL busy_result: got %h %h want %h %h", out_data, out_key, exp_ct(d, k), exp_rk(k));
        end
        @(negedge clk);
        vectors++;
        if (bus_viol != 0) begin
            miscompares++;
            $display("FAIL bus_rules: got %0d violations want 0", bus_viol);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_timeout;
        test_reset_mid_write;
        test_back_to_back;
        test_busy_input;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/encrypter_host.md
# encrypter_host

Bus-initiator front end for the encrypter register interface. It accepts a 64-bit plaintext block and a 64-bit key on a valid/ready handshake and drives the byte-wide memory-mapped port to run one encryption. That port is byte_write, addr, we, re and byte_read. The block writes the operands, pulses the command bit, polls status, reads back ciphertext and round key, and returns both on a second valid/ready handshake. It sits between the system datapath and the encrypter register interface.

## Interface
- SET_HOLD, 2: idle cycles held after the set write before the clear write (minimum 2).
- POLL_LIMIT, 1024: maximum status polls before the transaction is aborted with a timeout.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  source offers in_data/in_key.
- in_ready  output  1  high only in IDLE.
- in_data  input  [0:63]  plaintext; byte k = [8k:8k+7].
- in_key  input  [0:63]  key; same byte order.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts result.
- out_data  output  [0:63]  ciphertext.
- out_key  output  [0:63]  round key.
- out_timeout  output  1  qualifies out_valid: the poll limit was hit.
- byte_write  output  [0:7]  write byte to the register interface.
- addr  output  [5:0]  register address.
- we  output  1  write enable.
- re  output  1  read enable.
- byte_read  input  [0:7]  read byte, registered, valid 1 cycle after re.

## Operation
- Register map:
  - 0: command. byte index 0 = set, index 4 = status.
  - 1..8: data in.
  - 9..16: data out.
  - 17..24: key in before start, round key after completion.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data/in_key and go to WRITE.
- WRITE, 16 cycles, we=1:
  - cycles 0..7: addr 1..8 carry data bytes 0..7.
  - cycles 8..15: addr 17..24 carry key bytes 0..7.
- SET, 1 cycle: we=1, addr=0, byte_write=8'b1000_0000.
- HOLD, SET_HOLD cycles: we=re=0.
- CLEAR, 1 cycle: we=1, addr=0, byte_write=0. This also clears any stale status bit.
- GAP, 2 cycles: idle.
- POLL_RD: re=1, addr=0.
- POLL_CHK: bus idle. Sample byte_read[4].
  - If 1, go to READ.
  - Else increment the poll counter.
  - If the counter equals POLL_LIMIT, go to DONE with out_timeout=1 and out_data=out_key=0.
  - Otherwise go back to POLL_RD.
- READ, 16 cycles: re=1, addr 9..24 in order. Each byte_read is captured on the following cycle. Addr 9+k goes to out_data byte k; addr 17+k goes to out_key byte k. One drain cycle follows, then DONE.
- DONE: out_valid=1, outputs stable. On out_ready, go to IDLE and clear out_valid and out_timeout.
- Bus rules:
  - we and re are never high together.
  - byte_write=0 whenever we=0.
  - addr=0 whenever we=re=0.
- in_valid outside IDLE is ignored. The source must hold its data.
- No same-cycle accept after DONE: in_ready rises the cycle after the out handshake.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0, out_timeout=0.
  - out_data=0, out_key=0.
  - we=0, re=0, addr=0, byte_write=0.
  - FSM in IDLE, poll counter 0.
- Latency from accept edge to out_valid = 16 + 1 + SET_HOLD + 1 + 2 + 2P + 17 cycles, where P = number of polls. With defaults and P=1 this is 41.
- Timeout path: out_valid asserts 2·POLL_LIMIT cycles after GAP ends.
- The poll counter is wide enough for POLL_LIMIT and saturates. It resets on every accept.
- Reset mid-operation: all outputs return to reset values asynchronously and any latched operands are discarded. The responder keeps whatever bytes were already written. The next transaction rewrites all 17 command/operand registers, so this is safe.
- out_ready high while out_valid is low has no effect. out_valid never drops without out_ready.

## Test plan
- Basic run:
  - Stimulus: responder model raises status 5 cycles after CLEAR; data=0x0123456789ABCDEF, key=0x0F1E2D3C4B5A6978; sink always ready.
  - Required: write trace is addr 1..8, 17..24, 0(0x80), 0(0x00); reads follow; out_data and out_key match the model; latency matches the formula.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles after out_valid.
  - Required: outputs stable; in_ready stays 0; accept happens on the cycle after out_ready rises.
- Timeout:
  - Stimulus: POLL_LIMIT=4; status never set.
  - Required: exactly 4 re pulses at addr 0; out_valid with out_timeout=1 and out_data=out_key=0; next transaction runs normally.
- Reset mid-WRITE:
  - Stimulus: drop rst_n at WRITE cycle 6.
  - Required: we=0 immediately; in_ready=1 once rst_n releases; a following transaction completes correctly.
- Back-to-back:
  - Stimulus: in_valid held high with two distinct operand sets.
  - Required: second accept exactly 1 cycle after the first out handshake; no stale status leaks into the second result.
- Busy input:
  - Stimulus: change in_data while the FSM is in POLL.
  - Required: result reflects the original latched operands.
